// File: rtl/usb_ls_xfer_arbiter.sv
// Low-speed USB transfer arbiter.
// Grants one of two requesters round-robin, hands its token/data packet pair to the PHY through
// a toggle handshake, waits for the device response, retries NAKs on frame boundaries and
// returns a classified result with a one-cycle done pulse.
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   req_valid_i/ctrl/size/data     per-requester transaction request ({r1,r0} packing)
//   req_done_o, rsp_*_o            completion pulse and result/PID/packet of the last transfer
//   busy_o                         high whenever a transfer is in flight
//   phy_connected_i, phy_frame_i   device present, frame toggle
//   phy_send_*                     transmit toggle handshake and packet pair
//   phy_recv_*, phy_pid_i          receive toggle handshake and received PID/packet
module usb_ls_xfer_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 24000,
    parameter int unsigned NAK_RETRIES    = 3
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [1:0]   req_valid_i,
    input  logic [63:0]  req_ctrl_i,
    input  logic [11:0]  req_ctrl_size_i,
    input  logic [191:0] req_data_i,
    input  logic [13:0]  req_data_size_i,
    output logic [1:0]   req_done_o,
    output logic [1:0]   rsp_result_o,
    output logic [7:0]   rsp_pid_o,
    output logic [95:0]  rsp_data_o,
    output logic         busy_o,
    input  logic         phy_connected_i,
    input  logic         phy_frame_i,
    output logic         phy_send_req_o,
    input  logic         phy_send_ack_i,
    output logic [31:0]  phy_send_ctrl_o,
    output logic [5:0]   phy_send_ctrl_size_o,
    output logic [95:0]  phy_send_data_o,
    output logic [6:0]   phy_send_data_size_o,
    input  logic         phy_recv_evt_i,
    output logic         phy_recv_ack_o,
    input  logic [7:0]   phy_pid_i,
    input  logic [95:0]  phy_recv_data_i
);

    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RetryW = $clog2(NAK_RETRIES + 2);

    localparam logic [1:0] ResOk    = 2'd0;
    localparam logic [1:0] ResNak   = 2'd1;
    localparam logic [1:0] ResStall = 2'd2;
    localparam logic [1:0] ResErr   = 2'd3;

    typedef enum logic [2:0] {StIdle, StSend, StWaitTx, StWaitRx, StRetry, StDone} state_e;

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_q, last_d;
    logic [1:0]          blocked_q, blocked_d;
    logic                send_req_q, send_req_d;
    logic                recv_ack_q;
    logic                frame_q;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [RetryW-1:0]   retry_q, retry_d;
    logic [31:0]         lat_ctrl_q, lat_ctrl_d;
    logic [5:0]          lat_csz_q, lat_csz_d;
    logic [95:0]         lat_data_q, lat_data_d;
    logic [6:0]          lat_dsz_q, lat_dsz_d;
    logic [7:0]          cap_pid_q, cap_pid_d;
    logic [95:0]         cap_data_q, cap_data_d;
    logic [1:0]          rsp_result_q, rsp_result_d;
    logic [7:0]          rsp_pid_q, rsp_pid_d;
    logic [95:0]         rsp_data_q, rsp_data_d;

    logic [1:0] eligible;
    logic       pick;
    logic       recv_pend;
    logic       finish;
    logic [1:0] result;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        send_req_d   = send_req_q;
        timer_d      = timer_q;
        retry_d      = retry_q;
        lat_ctrl_d   = lat_ctrl_q;
        lat_csz_d    = lat_csz_q;
        lat_data_d   = lat_data_q;
        lat_dsz_d    = lat_dsz_q;
        cap_pid_d    = cap_pid_q;
        cap_data_d   = cap_data_q;
        rsp_result_d = rsp_result_q;
        rsp_pid_d    = rsp_pid_q;
        rsp_data_d   = rsp_data_q;
        finish       = 1'b0;
        result       = ResErr;
        // An aborted requester stays masked until it drops valid.
        blocked_d    = blocked_q & req_valid_i;
        eligible     = req_valid_i & ~blocked_q;
        pick         = (eligible == 2'b11) ? ~last_q : eligible[1];
        recv_pend    = phy_recv_evt_i != recv_ack_q;

        if (state_q != StIdle && state_q != StDone && !phy_connected_i) begin
            finish             = 1'b1;
            result             = ResErr;
            blocked_d[grant_q] = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (phy_connected_i && eligible != 2'b00) begin
                        grant_d    = pick;
                        last_d     = pick;
                        lat_ctrl_d = pick ? req_ctrl_i[63:32] : req_ctrl_i[31:0];
                        lat_csz_d  = pick ? req_ctrl_size_i[11:6] : req_ctrl_size_i[5:0];
                        lat_data_d = pick ? req_data_i[191:96] : req_data_i[95:0];
                        lat_dsz_d  = pick ? req_data_size_i[13:7] : req_data_size_i[6:0];
                        retry_d    = '0;
                        timer_d    = '0;
                        cap_pid_d  = '0;
                        cap_data_d = '0;
                        state_d    = StSend;
                    end
                end
                StSend: begin
                    if (phy_send_ack_i == send_req_q) begin
                        send_req_d = ~send_req_q;
                        state_d    = StWaitTx;
                    end
                end
                StWaitTx: begin
                    if (phy_send_ack_i == send_req_q) begin
                        timer_d = '0;
                        state_d = StWaitRx;
                    end
                end
                StWaitRx: begin
                    if (recv_pend) begin
                        cap_pid_d  = phy_pid_i;
                        cap_data_d = phy_recv_data_i;
                        case (phy_pid_i)
                            8'hD2, 8'hC3, 8'h4B: begin
                                finish = 1'b1;
                                result = ResOk;
                            end
                            8'h5A: begin
                                if (retry_q < RetryW'(NAK_RETRIES)) begin
                                    state_d = StRetry;
                                end else begin
                                    finish = 1'b1;
                                    result = ResNak;
                                end
                            end
                            8'h1E: begin
                                finish = 1'b1;
                                result = ResStall;
                            end
                            default: begin
                                finish = 1'b1;
                                result = ResErr;
                            end
                        endcase
                    end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
                        finish = 1'b1;
                        result = ResErr;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                StRetry: begin
                    if (phy_frame_i != frame_q) begin
                        retry_d = retry_q + 1'b1;
                        state_d = StSend;
                    end
                end
                StDone: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end

        // Response registers only move on DONE entry so they stay stable between pulses.
        if (finish) begin
            state_d      = StDone;
            rsp_result_d = result;
            rsp_pid_d    = cap_pid_d;
            rsp_data_d   = cap_data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_q       <= 1'b1;
            blocked_q    <= 2'b00;
            send_req_q   <= 1'b0;
            recv_ack_q   <= 1'b0;
            frame_q      <= 1'b0;
            timer_q      <= '0;
            retry_q      <= '0;
            lat_ctrl_q   <= '0;
            lat_csz_q    <= '0;
            lat_data_q   <= '0;
            lat_dsz_q    <= '0;
            cap_pid_q    <= '0;
            cap_data_q   <= '0;
            rsp_result_q <= '0;
            rsp_pid_q    <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            blocked_q    <= blocked_d;
            send_req_q   <= send_req_d;
            // Every received packet is acknowledged; only WAIT_RX keeps its contents.
            recv_ack_q   <= phy_recv_evt_i;
            frame_q      <= phy_frame_i;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            lat_ctrl_q   <= lat_ctrl_d;
            lat_csz_q    <= lat_csz_d;
            lat_data_q   <= lat_data_d;
            lat_dsz_q    <= lat_dsz_d;
            cap_pid_q    <= cap_pid_d;
            cap_data_q   <= cap_data_d;
            rsp_result_q <= rsp_result_d;
            rsp_pid_q    <= rsp_pid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign req_done_o           = (state_q == StDone) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result_o         = rsp_result_q;
    assign rsp_pid_o            = rsp_pid_q;
    assign rsp_data_o           = rsp_data_q;
    assign busy_o               = state_q != StIdle;
    assign phy_send_req_o       = send_req_q;
    assign phy_send_ctrl_o      = lat_ctrl_q;
    assign phy_send_ctrl_size_o = lat_csz_q;
    assign phy_send_data_o      = lat_data_q;
    assign phy_send_data_size_o = lat_dsz_q;
    assign phy_recv_ack_o       = recv_ack_q;

endmodule

// File: tb/tb_usb_ls_xfer_arbiter.sv
// Testbench for usb_ls_xfer_arbiter: plays the PHY, keeps a transaction-level model of
// arbitration and response classification, and checks every completion against it.
module tb_usb_ls_xfer_arbiter;

    localparam int TO = 40;
    localparam int NR = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid;
    logic [63:0]  req_ctrl;
    logic [11:0]  req_ctrl_size;
    logic [191:0] req_data;
    logic [13:0]  req_data_size;
    logic [1:0]   req_done;
    logic [1:0]   rsp_result;
    logic [7:0]   rsp_pid;
    logic [95:0]  rsp_data;
    logic         busy;
    logic         phy_connected;
    logic         phy_frame;
    logic         phy_send_req;
    logic         phy_send_ack;
    logic [31:0]  phy_send_ctrl;
    logic [5:0]   phy_send_ctrl_size;
    logic [95:0]  phy_send_data;
    logic [6:0]   phy_send_data_size;
    logic         phy_recv_evt;
    logic         phy_recv_ack;
    logic [7:0]   phy_pid;
    logic [95:0]  phy_recv_data;

    always #5 clk = ~clk;

    usb_ls_xfer_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .NAK_RETRIES   (NR)
    ) dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .req_valid_i         (req_valid),
        .req_ctrl_i          (req_ctrl),
        .req_ctrl_size_i     (req_ctrl_size),
        .req_data_i          (req_data),
        .req_data_size_i     (req_data_size),
        .req_done_o          (req_done),
        .rsp_result_o        (rsp_result),
        .rsp_pid_o           (rsp_pid),
        .rsp_data_o          (rsp_data),
        .busy_o              (busy),
        .phy_connected_i     (phy_connected),
        .phy_frame_i         (phy_frame),
        .phy_send_req_o      (phy_send_req),
        .phy_send_ack_i      (phy_send_ack),
        .phy_send_ctrl_o     (phy_send_ctrl),
        .phy_send_ctrl_size_o(phy_send_ctrl_size),
        .phy_send_data_o     (phy_send_data),
        .phy_send_data_size_o(phy_send_data_size),
        .phy_recv_evt_i      (phy_recv_evt),
        .phy_recv_ack_o      (phy_recv_ack),
        .phy_pid_i           (phy_pid),
        .phy_recv_data_i     (phy_recv_data)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          sends = 0;
    logic [31:0] snd_ctrl;
    logic [5:0]  snd_csz;
    logic [95:0] snd_data;
    logic [6:0]  snd_dsz;
    int          tx_timer = -1;
    int          rx_timer = -1;
    int          rx_entry = 0;
    int          pidq[$];
    logic [95:0] datq[$];
    bit          nak_pending = 1'b0;
    bit          frame_seen = 1'b0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [1:0]  done_v;
    logic [1:0]  done_res;
    logic [7:0]  done_pid;
    logic [95:0] done_data;
    logic        last_g = 1'b1;
    int          scr0[$];
    int          scr1[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of PHY behaviour, evaluated on the falling edge.
    task automatic tick();
        int          p;
        logic [95:0] d;
        @(negedge clk);
        cyc++;
        if (cyc % 8 == 0) begin
            phy_frame  = ~phy_frame;
            frame_seen = 1'b1;
        end
        if (rx_timer == 0) begin
            rx_timer = -1;
            if (pidq.size() > 0) begin
                p = pidq.pop_front();
                d = datq.pop_front();
                if (p >= 0) begin
                    phy_pid       = p[7:0];
                    phy_recv_data = d;
                    phy_recv_evt  = ~phy_recv_evt;
                    if (p == 'h5A) begin
                        nak_pending = 1'b1;
                        frame_seen  = 1'b0;
                    end
                end
            end
        end else if (rx_timer > 0) begin
            rx_timer--;
        end
        if (phy_send_req !== phy_send_ack && tx_timer < 0) begin
            sends++;
            snd_ctrl = phy_send_ctrl;
            snd_csz  = phy_send_ctrl_size;
            snd_data = phy_send_data;
            snd_dsz  = phy_send_data_size;
            if (nak_pending) begin
                chk("retry_after_frame", frame_seen, 1'b1);
                nak_pending = 1'b0;
            end
            tx_timer = $urandom_range(1, 3);
        end
        if (tx_timer > 0) tx_timer--;
        if (tx_timer == 0) begin
            phy_send_ack = phy_send_req;
            tx_timer     = -1;
            rx_entry     = cyc + 1;
            rx_timer     = $urandom_range(1, 4);
        end
        if (req_done !== 2'b00) begin
            done_cnt++;
            done_cyc    = cyc;
            done_v      = req_done;
            done_res    = rsp_result;
            done_pid    = rsp_pid;
            done_data   = rsp_data;
            nak_pending = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        phy_send_ack = 1'b0;
        phy_recv_evt = 1'b0;
        tx_timer     = -1;
        rx_timer     = -1;
        nak_pending  = 1'b0;
        pidq.delete();
        datq.delete();
        req_valid    = 2'b00;
        last_g       = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic set_fields(input int r);
        if (r == 0) begin
            req_ctrl[31:0]     = $urandom;
            req_ctrl_size[5:0] = 6'($urandom_range(0, 63));
            req_data[95:0]     = {$urandom, $urandom, $urandom};
            req_data_size[6:0] = 7'($urandom_range(0, 96));
        end else begin
            req_ctrl[63:32]     = $urandom;
            req_ctrl_size[11:6] = 6'($urandom_range(0, 63));
            req_data[191:96]    = {$urandom, $urandom, $urandom};
            req_data_size[13:7] = 7'($urandom_range(0, 96));
        end
    endtask

    // Response script: some NAKs, then a terminal response (-1 = device silent).
    task automatic gen_script(input int r);
        int q[$];
        int k;
        int pool[6];
        pool = '{'hD2, 'hC3, 'h4B, 'h1E, 'h96, -1};
        k = $urandom_range(0, 5);
        for (int i = 0; i < k && i <= NR; i++) q.push_back('h5A);
        if (k <= NR) q.push_back(pool[$urandom_range(0, 5)]);
        if (r == 0) scr0 = q;
        else scr1 = q;
    endtask

    // Serve the next grant chosen by the round-robin rule and check its completion.
    task automatic serve_one(input bit drop_mid);
        logic        g;
        int          scr[$];
        int          p;
        int          exp_sends;
        int          retries;
        int          start_done;
        logic [1:0]  exp_res;
        logic [7:0]  exp_pid;
        logic [95:0] exp_dat;
        logic [95:0] d;
        logic [31:0] e_ctrl;
        logic [5:0]  e_csz;
        logic [95:0] e_data;
        logic [6:0]  e_dsz;
        bit          tmo;
        bit          got;
        g = (req_valid == 2'b11) ? ~last_g : req_valid[1];
        if (g) scr = scr1;
        else scr = scr0;
        e_ctrl = g ? req_ctrl[63:32] : req_ctrl[31:0];
        e_csz  = g ? req_ctrl_size[11:6] : req_ctrl_size[5:0];
        e_data = g ? req_data[191:96] : req_data[95:0];
        e_dsz  = g ? req_data_size[13:7] : req_data_size[6:0];
        pidq.delete();
        datq.delete();
        exp_sends = 0;
        retries   = 0;
        exp_res   = 2'd3;
        exp_pid   = 8'h00;
        exp_dat   = '0;
        tmo       = 1'b0;
        foreach (scr[j]) begin
            d = {$urandom, $urandom, $urandom};
            pidq.push_back(scr[j]);
            datq.push_back(d);
            exp_sends++;
            p = scr[j];
            if (p < 0) begin
                exp_res = 2'd3;
                tmo     = 1'b1;
                break;
            end
            if (p == 'h5A && retries < NR) begin
                retries++;
                continue;
            end
            exp_pid = p[7:0];
            exp_dat = d;
            if (p == 'hD2 || p == 'hC3 || p == 'h4B) exp_res = 2'd0;
            else if (p == 'h5A) exp_res = 2'd1;
            else if (p == 'h1E) exp_res = 2'd2;
            else exp_res = 2'd3;
            break;
        end
        sends      = 0;
        start_done = done_cnt;
        got        = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            tick();
            if (drop_mid && sends > 0) req_valid[g] = 1'b0;
            if (done_cnt != start_done) got = 1'b1;
        end
        chk("done_seen", got, 1'b1);
        if (got) begin
            chk("done_vec", done_v, g ? 2'b10 : 2'b01);
            chk("rsp_result", done_res, exp_res);
            chk("send_count", sends, exp_sends);
            chk("send_ctrl", snd_ctrl, e_ctrl);
            chk("send_ctrl_size", snd_csz, e_csz);
            chk("send_data", snd_data, e_data);
            chk("send_data_size", snd_dsz, e_dsz);
            if (tmo) begin
                chk("timeout_latency", done_cyc - rx_entry, TO);
            end else begin
                chk("rsp_pid", done_pid, exp_pid);
                chk("rsp_data", done_data, exp_dat);
            end
        end
        req_valid[g] = 1'b0;
        last_g       = g;
        tick();
        chk("done_pulse_width", req_done, 2'b00);
        chk("rsp_hold", rsp_result, exp_res);
    endtask

    initial begin
        int c;
        req_valid     = 2'b00;
        req_ctrl      = '0;
        req_ctrl_size = '0;
        req_data      = '0;
        req_data_size = '0;
        phy_connected = 1'b1;
        phy_frame     = 1'b0;
        phy_pid       = '0;
        phy_recv_data = '0;
        do_reset();

        // Reset state
        chk("rst_done", req_done, 2'b00);
        chk("rst_result", rsp_result, 2'd0);
        chk("rst_pid", rsp_pid, 8'h00);
        chk("rst_data", rsp_data, 96'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_send_req", phy_send_req, 1'b0);
        chk("rst_recv_ack", phy_recv_ack, 1'b0);

        // Single r0 transfer, PHY answers C3
        set_fields(0);
        req_ctrl[31:0] = 32'h1000_6980;
        scr0.delete();
        scr0.push_back('hC3);
        req_valid = 2'b01;
        serve_one(1'b0);

        // Simultaneous requesters, then r0 re-requests while r1 is still pending
        do_reset();
        set_fields(0);
        set_fields(1);
        scr0.delete();
        scr0.push_back('hD2);
        scr1.delete();
        scr1.push_back('h4B);
        req_valid = 2'b11;
        serve_one(1'b0);
        req_valid[0] = 1'b1;
        scr0.delete();
        scr0.push_back('hC3);
        serve_one(1'b0);
        serve_one(1'b0);

        // NAK four times: retries exhausted
        set_fields(1);
        scr1.delete();
        repeat (4) scr1.push_back('h5A);
        req_valid = 2'b10;
        serve_one(1'b0);

        // Silent device: timeout
        set_fields(0);
        scr0.delete();
        scr0.push_back(-1);
        req_valid = 2'b01;
        serve_one(1'b0);

        // Disconnect while waiting for the response
        pidq.delete();
        datq.delete();
        pidq.push_back(-1);
        datq.push_back('0);
        sends     = 0;
        req_valid = 2'b01;
        for (int i = 0; i < 100 && !(sends == 1 && tx_timer < 0); i++) tick();
        chk("disc_send", sends, 1);
        tick();
        tick();
        chk("busy_in_xfer", busy, 1'b1);
        phy_connected = 1'b0;
        tick();
        chk("disc_done", req_done, 2'b01);
        chk("disc_result", rsp_result, 2'd3);
        last_g = 1'b0;
        tick();
        phy_connected = 1'b1;
        repeat (5) tick();
        chk("disc_no_regrant", busy, 1'b0);
        req_valid = 2'b00;
        tick();
        scr0.delete();
        scr0.push_back('hC3);
        req_valid = 2'b01;
        serve_one(1'b0);

        // Stray receive event while idle
        c = done_cnt;
        phy_recv_evt = ~phy_recv_evt;
        tick();
        tick();
        chk("stray_acked", phy_recv_ack, phy_recv_evt);
        chk("stray_no_done", done_cnt, c);
        chk("stray_idle", busy, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 20; it++) begin
            set_fields(0);
            set_fields(1);
            gen_script(0);
            gen_script(1);
            req_valid = 2'($urandom_range(1, 3));
            while (req_valid != 2'b00) serve_one($urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
